// File: rtl/lock_session_arbiter.sv
// lock_session_arbiter
// Shares one combination-lock code checker between two consoles (A and B).
// One console at a time owns an entry session; the checker is cleared before
// every session and after every session end. Only the owner's valid digits
// (0..9) are forwarded, one cycle after the console strobe. An inactivity
// timeout aborts idle sessions and a failed code locks both consoles out.

module lock_session_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned LOCKOUT_CYCLES = 5000,
   parameter int unsigned CNT_W          = 13
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_a,
   input  logic       req_b,
   input  logic [3:0] numero_a,
   input  logic [3:0] numero_b,
   input  logic       insere_a,
   input  logic       insere_b,
   input  logic       lock_ok,
   input  logic       lock_fail,
   output logic [3:0] lock_numero,
   output logic       lock_insere,
   output logic       lock_clear,
   output logic       grant_a,
   output logic       grant_b,
   output logic       unlocked,
   output logic       lockout,
   output logic [2:0] digit_count
);

   localparam int unsigned DIG_W  = 4;
   localparam int unsigned DCNT_W = 3;

   localparam logic [DIG_W-1:0]  DIGIT_LIMIT  = DIG_W'(10);
   localparam logic [DCNT_W-1:0] DCNT_MAX     = DCNT_W'(7);
   localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  LOCKOUT_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_SESSION = 3'd2,
      ST_OPEN    = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic                 pick_b;

   logic                 owner_req;
   logic                 owner_ins;
   logic [DIG_W-1:0]     owner_num;
   logic                 digit_ok;
   logic                 timeout_hit;
   logic                 lockout_done;
   logic                 want_a;
   logic                 want_b;

   // Select the session owner's console inputs; the other console is ignored.
   always_comb begin
      owner_req = req_a;
      owner_ins = insere_a;
      owner_num = numero_a;
      if (grant_b) begin
         owner_req = req_b;
         owner_ins = insere_b;
         owner_num = numero_b;
      end
   end

   // Event decode: valid digit, timer expiries and round-robin arbitration.
   always_comb begin
      digit_ok     = owner_ins && (owner_num < DIGIT_LIMIT);
      timeout_hit  = (cnt == TIMEOUT_LAST);
      lockout_done = (cnt == LOCKOUT_LAST);
      want_a       = req_a && (!req_b || !pick_b);
      want_b       = req_b && !want_a;
   end

   // Session FSM with all outputs registered; strobes default low each cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         pick_b      <= 1'b0;
         lock_numero <= '0;
         lock_insere <= 1'b0;
         lock_clear  <= 1'b0;
         grant_a     <= 1'b0;
         grant_b     <= 1'b0;
         unlocked    <= 1'b0;
         lockout     <= 1'b0;
         digit_count <= '0;
      end else begin
         lock_insere <= 1'b0;
         lock_clear  <= 1'b0;

         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (want_a) begin
                  grant_a    <= 1'b1;
                  pick_b     <= 1'b1;
                  lock_clear <= 1'b1;
                  state      <= ST_CLEAR;
               end else if (want_b) begin
                  grant_b    <= 1'b1;
                  pick_b     <= 1'b0;
                  lock_clear <= 1'b1;
                  state      <= ST_CLEAR;
               end
            end

            ST_CLEAR: begin
               cnt         <= '0;
               digit_count <= '0;
               state       <= ST_SESSION;
            end

            ST_SESSION: begin
               if (lock_fail) begin
                  lockout <= 1'b1;
                  grant_a <= 1'b0;
                  grant_b <= 1'b0;
                  cnt     <= '0;
                  state   <= ST_LOCKOUT;
               end else if (lock_ok) begin
                  unlocked <= 1'b1;
                  state    <= ST_OPEN;
               end else if (!owner_req || timeout_hit) begin
                  // abandoned or idle session: release and reset the checker
                  lock_clear <= 1'b1;
                  grant_a    <= 1'b0;
                  grant_b    <= 1'b0;
                  cnt        <= '0;
                  state      <= ST_IDLE;
               end else if (digit_ok) begin
                  lock_numero <= owner_num;
                  lock_insere <= 1'b1;
                  cnt         <= '0;
                  if (digit_count != DCNT_MAX) begin
                     digit_count <= digit_count + DCNT_W'(1);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_OPEN: begin
               if (!owner_req) begin
                  unlocked   <= 1'b0;
                  lock_clear <= 1'b1;
                  grant_a    <= 1'b0;
                  grant_b    <= 1'b0;
                  state      <= ST_IDLE;
               end
            end

            ST_LOCKOUT: begin
               if (lockout_done) begin
                  lockout    <= 1'b0;
                  lock_clear <= 1'b1;
                  cnt        <= '0;
                  state      <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lock_session_arbiter.sv
// Bench for lock_session_arbiter: scenario tasks plus a digit scoreboard that
// expects each accepted digit on lock_numero exactly one cycle after its strobe.

module tb_lock_session_arbiter;

   localparam int unsigned TO = 8;
   localparam int unsigned LO = 10;
   localparam int unsigned CW = 13;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req_a = 1'b0, req_b = 1'b0;
   logic [3:0] numero_a = 4'd0, numero_b = 4'd0;
   logic       insere_a = 1'b0, insere_b = 1'b0;
   logic       lock_ok = 1'b0, lock_fail = 1'b0;
   logic [3:0] lock_numero;
   logic       lock_insere, lock_clear, grant_a, grant_b, unlocked, lockout;
   logic [2:0] digit_count;

   typedef struct {
      logic [3:0]  num;
      int unsigned due;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   lock_session_arbiter #(
      .TIMEOUT_CYCLES(TO),
      .LOCKOUT_CYCLES(LO),
      .CNT_W         (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_a      (req_a),
      .req_b      (req_b),
      .numero_a   (numero_a),
      .numero_b   (numero_b),
      .insere_a   (insere_a),
      .insere_b   (insere_b),
      .lock_ok    (lock_ok),
      .lock_fail  (lock_fail),
      .lock_numero(lock_numero),
      .lock_insere(lock_insere),
      .lock_clear (lock_clear),
      .grant_a    (grant_a),
      .grant_b    (grant_b),
      .unlocked   (unlocked),
      .lockout    (lockout),
      .digit_count(digit_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every forwarded digit must match the next expected one, on time.
   always @(negedge clk) begin
      exp_t e;
      if (reset && lock_insere) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL strobe_unexpected: lock_numero=%0d at cycle %0d, required no strobe",
                     lock_numero, cyc);
         end else begin
            e = sb.pop_front();
            if (lock_numero !== e.num || cyc !== e.due || lock_clear !== 1'b0) begin
               n_bad++;
               $display("FAIL strobe_digit: got numero=%0d cycle=%0d clear=%0b, required numero=%0d cycle=%0d clear=0",
                        lock_numero, cyc, lock_clear, e.num, e.due);
            end
         end
      end
   end

   function automatic logic [12:0] outs();
      return {lock_numero, lock_insere, lock_clear, grant_a, grant_b,
              unlocked, lockout, digit_count};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_a = 0; req_b = 0; insere_a = 0; insere_b = 0;
      numero_a = 0; numero_b = 0; lock_ok = 0; lock_fail = 0;
      reset = 0;
      tick();
      tick();
      reset = 1;
   endtask

   // Leaves the DUT in its first SESSION cycle owned by A.
   task automatic start_session_a();
      req_a = 1;
      tick();
      tick();
   endtask

   task automatic send_digit_a(input logic [3:0] num);
      numero_a = num;
      insere_a = 1;
      sb.push_back('{num, cyc + 1});
      tick();
      insere_a = 0;
   endtask

   task automatic test_reset();
      req_a = 1; req_b = 1; insere_a = 1; numero_a = 4'd3;
      reset = 0;
      tick();
      tick();
      n_cmp++;
      if (outs() !== 13'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h, required 0", outs());
      end
      do_reset();
   endtask

   task automatic test_digits();
      do_reset();
      req_a = 1;
      tick();
      n_cmp++;
      if ({grant_a, grant_b, lock_clear} !== 3'b101) begin
         n_bad++;
         $display("FAIL grant_clear: got %b, required 101", {grant_a, grant_b, lock_clear});
      end
      tick();
      n_cmp++;
      if ({grant_a, grant_b, lock_clear} !== 3'b100) begin
         n_bad++;
         $display("FAIL clear_one_cycle: got %b, required 100", {grant_a, grant_b, lock_clear});
      end
      send_digit_a(4'd5); tick();
      send_digit_a(4'd3); tick();
      send_digit_a(4'd7); tick();
      n_cmp++;
      if (digit_count !== 3'd3) begin
         n_bad++;
         $display("FAIL digit_count3: got %0d, required 3", digit_count);
      end
      for (int i = 0; i < 6; i++) begin
         send_digit_a(4'(i));
         tick();
      end
      n_cmp++;
      if (digit_count !== 3'd7) begin
         n_bad++;
         $display("FAIL digit_count_sat: got %0d, required 7", digit_count);
      end
      req_a = 0;
      tick();
      n_cmp++;
      if ({grant_a, lock_clear} !== 2'b01) begin
         n_bad++;
         $display("FAIL req_drop_abort: got %b, required 01", {grant_a, lock_clear});
      end
      tick();
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL digits_missing: %0d outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_timeout();
      do_reset();
      start_session_a();
      for (int i = 1; i <= 7; i++) tick();
      n_cmp++;
      if ({grant_a, lock_clear} !== 2'b10) begin
         n_bad++;
         $display("FAIL timeout_early: got %b, required 10", {grant_a, lock_clear});
      end
      tick();
      n_cmp++;
      if ({grant_a, lock_clear} !== 2'b01) begin
         n_bad++;
         $display("FAIL timeout_abort: got %b, required 01", {grant_a, lock_clear});
      end
      req_a = 0;
      tick();
      // a valid digit restarts the inactivity window
      do_reset();
      start_session_a();
      tick();
      tick();
      send_digit_a(4'd9);
      for (int i = 1; i <= 7; i++) tick();
      n_cmp++;
      if ({grant_a, lock_clear} !== 2'b10) begin
         n_bad++;
         $display("FAIL timeout_reload_early: got %b, required 10", {grant_a, lock_clear});
      end
      tick();
      n_cmp++;
      if ({grant_a, lock_clear} !== 2'b01) begin
         n_bad++;
         $display("FAIL timeout_reload_abort: got %b, required 01", {grant_a, lock_clear});
      end
      req_a = 0;
      tick();
   endtask

   task automatic test_ignored();
      do_reset();
      start_session_a();
      tick(); tick(); tick();
      insere_a = 1; numero_a = 4'd12;
      insere_b = 1; numero_b = 4'd5;
      tick();
      insere_a = 0; insere_b = 0;
      tick(); tick(); tick();
      n_cmp++;
      if ({grant_a, lock_clear, digit_count} !== 5'b10_000) begin
         n_bad++;
         $display("FAIL ignored_digits: got %b, required 10000", {grant_a, lock_clear, digit_count});
      end
      tick();
      n_cmp++;
      if ({grant_a, lock_clear} !== 2'b01) begin
         n_bad++;
         $display("FAIL ignored_no_reload: got %b, required 01", {grant_a, lock_clear});
      end
      req_a = 0;
      tick();
   endtask

   task automatic test_round_robin();
      do_reset();
      req_a = 1; req_b = 1;
      tick();
      n_cmp++;
      if ({grant_a, grant_b} !== 2'b10) begin
         n_bad++;
         $display("FAIL rr_first: got %b, required 10", {grant_a, grant_b});
      end
      tick();
      req_a = 0;
      tick();
      n_cmp++;
      if ({grant_a, grant_b, lock_clear} !== 3'b001) begin
         n_bad++;
         $display("FAIL rr_a_release: got %b, required 001", {grant_a, grant_b, lock_clear});
      end
      tick();
      n_cmp++;
      if ({grant_a, grant_b, lock_clear} !== 3'b011) begin
         n_bad++;
         $display("FAIL rr_grant_b: got %b, required 011", {grant_a, grant_b, lock_clear});
      end
      tick();
      req_b = 0;
      tick();
      req_a = 1; req_b = 1;
      tick();
      n_cmp++;
      if ({grant_a, grant_b} !== 2'b10) begin
         n_bad++;
         $display("FAIL rr_back_to_a: got %b, required 10", {grant_a, grant_b});
      end
      req_a = 0; req_b = 0;
      tick(); tick(); tick();
   endtask

   task automatic test_lockout();
      do_reset();
      start_session_a();
      lock_fail = 1; req_b = 1;
      tick();
      req_a = 0;
      n_cmp++;
      if ({lockout, grant_a, grant_b} !== 3'b100) begin
         n_bad++;
         $display("FAIL lockout_enter: got %b, required 100", {lockout, grant_a, grant_b});
      end
      for (int i = 2; i <= 10; i++) begin
         tick();
         n_cmp++;
         if ({lockout, grant_b, lock_clear} !== 3'b100) begin
            n_bad++;
            $display("FAIL lockout_hold cycle %0d: got %b, required 100", i, {lockout, grant_b, lock_clear});
         end
      end
      tick();
      n_cmp++;
      if ({lockout, grant_b, lock_clear} !== 3'b001) begin
         n_bad++;
         $display("FAIL lockout_exit: got %b, required 001", {lockout, grant_b, lock_clear});
      end
      lock_fail = 0;
      tick();
      n_cmp++;
      if ({grant_b, lock_clear} !== 2'b11) begin
         n_bad++;
         $display("FAIL lockout_then_b: got %b, required 11", {grant_b, lock_clear});
      end
      req_b = 0;
      tick(); tick(); tick();
   endtask

   task automatic test_open();
      do_reset();
      start_session_a();
      lock_ok = 1; lock_fail = 1;
      tick();
      n_cmp++;
      if ({lockout, unlocked, grant_a} !== 3'b100) begin
         n_bad++;
         $display("FAIL fail_wins: got %b, required 100", {lockout, unlocked, grant_a});
      end
      do_reset();
      start_session_a();
      send_digit_a(4'd1);
      lock_ok = 1;
      tick();
      tick();
      n_cmp++;
      if ({unlocked, grant_a, lock_clear} !== 3'b110) begin
         n_bad++;
         $display("FAIL open_hold: got %b, required 110", {unlocked, grant_a, lock_clear});
      end
      req_a = 0;
      tick();
      n_cmp++;
      if ({unlocked, grant_a, lock_clear} !== 3'b001) begin
         n_bad++;
         $display("FAIL open_release: got %b, required 001", {unlocked, grant_a, lock_clear});
      end
      lock_ok = 0;
      tick();
      do_reset();
      start_session_a();
      lock_ok = 1;
      tick();
      reset = 0;
      tick();
      n_cmp++;
      if (outs() !== 13'd0) begin
         n_bad++;
         $display("FAIL reset_in_open: got %h, required 0", outs());
      end
      lock_ok = 0; req_a = 0;
      reset = 1;
      tick();
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL final_scoreboard: %0d outstanding, required 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_digits();
      test_timeout();
      test_ignored();
      test_round_robin();
      test_lockout();
      test_open();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
